// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive path, the transmit core and the
//   packet mux: receive FSM state encoding, data width and the packet start byte.
package uart_pkg;

  localparam int         UART_DATA_BITS  = 8;
  localparam logic [7:0] UART_START_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo
//   Small synchronous first-word-fall-through FIFO. The head entry is always
//   presented on dout while the FIFO is non-empty.
// Ports
//   clk    in   single clock
//   rst_n  in   synchronous active-low reset; empties the FIFO
//   push   in   write request for din; ignored when full unless pop is accepted
//   din    in   WIDTH-bit write data
//   full   out  DEPTH entries stored
//   pop    in   read request; ignored when empty
//   dout   out  head entry (mem[rd_ptr])
//   empty  out  no entries stored
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic do_pop;
  logic do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle;
  // the write lands in the slot being vacated.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser
//   Oversampling 8N1 UART receiver (LSB first) feeding a valid/ready byte
//   stream through a small output FIFO that absorbs bytes while the consumer
//   stalls.
// Ports
//   clk        in   single clock
//   rst_n      in   synchronous active-low reset; aborts any frame in progress
//   uart_rx    in   asynchronous serial line, idle high
//   rx_data    out  FIFO head byte, zero while rx_valid is low
//   rx_valid   out  FIFO non-empty
//   rx_ready   in   consumer accepts head when rx_valid && rx_ready
//   frame_err  out  1-cycle pulse when the stop bit is sampled low
//   overflow   out  1-cycle pulse when a good byte is dropped on a full FIFO
//   busy       out  receive FSM not idle
// CLKS_PER_BIT must be at least 8 so the half-bit start check is meaningful.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  // Line synchronizer; reset to the idle level so reset never looks like a start bit.
  logic rx_meta_q;
  logic rxs_q;

  uart_rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                        frame_err_q, frame_err_d;
  logic                        overflow_q, overflow_d;
  logic                        push_req;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [7:0] fifo_dout;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push_req    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Re-check the line half a bit in; a short low pulse is treated as noise.
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d              = '0;
          shreg_d[bit_idx_q] = rxs_q;
          if (bit_idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs_q) begin
            push_req = 1'b1;
            state_d  = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        // Hold here until the line is released so a long break reports once.
        if (rxs_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fifo_pop   = rx_ready && !fifo_empty;
  assign overflow_d = push_req && fifo_full && !fifo_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rx_meta_q   <= uart_rx;
      rxs_q       <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (shreg_q),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign rx_valid  = !fifo_empty;
  assign rx_data   = fifo_empty ? 8'h00 : fifo_dout;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE);

endmodule
